// File: rtl/id_token_if.sv
// id_token_if: character stream inputs and token status outputs of id_token_scanner.
interface id_token_if #(parameter int LEN_W = 8, parameter int CNT_W = 16);
  logic [7:0]       char;
  logic             char_valid;
  logic             underscore_en;
  logic             clear;
  logic             match;
  logic [LEN_W-1:0] cur_len;
  logic             token_done;
  logic [LEN_W-1:0] last_len;
  logic [CNT_W-1:0] token_count;
  modport master (output char, char_valid, underscore_en, clear,
                  input  match, cur_len, token_done, last_len, token_count);
  modport slave  (input  char, char_valid, underscore_en, clear,
                  output match, cur_len, token_done, last_len, token_count);
endinterface

// File: rtl/id_token_scanner.sv
// id_token_scanner: recognises alpha+ digit{MIN_DIGITS,} tokens and reports length and count statistics.
module id_token_scanner #(
  parameter int MIN_DIGITS = 1,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16
) (
  input logic       clk,
  input logic       rst_n,
  id_token_if.slave tok
);
  typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, MATCH} state_t;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, last_q, last_d, len_inc;
  logic [3:0]       dcnt_q, dcnt_d, dcnt_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, is_digit, is_alpha, reach;
  assign is_digit = tok.char >= 8'd48 && tok.char <= 8'd57;
  assign is_alpha = (tok.char >= 8'd65 && tok.char <= 8'd90) || (tok.char >= 8'd97 && tok.char <= 8'd122) ||
                    (tok.char == 8'd95 && tok.underscore_en);
  assign len_inc  = &len_q ? len_q : len_q + LEN_W'(1);
  assign dcnt_inc = dcnt_q >= 4'(MIN_DIGITS) ? dcnt_q : dcnt_q + 4'd1;
  // dcnt is zero in ALPHA and saturated in MATCH, so one digit rule covers every non-idle state
  assign reach    = dcnt_inc >= 4'(MIN_DIGITS);
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    dcnt_d  = dcnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (tok.clear) begin
      state_d = IDLE;
      len_d   = '0;
      dcnt_d  = '0;
      last_d  = '0;
      cnt_d   = '0;
    end else if (tok.char_valid) begin
      if (is_digit && state_q != IDLE) begin
        len_d   = len_inc;
        dcnt_d  = dcnt_inc;
        state_d = reach ? MATCH : DIGIT;
      end else if (is_alpha) begin
        state_d = ALPHA;
        len_d   = state_q == ALPHA ? len_inc : LEN_W'(1);
        dcnt_d  = '0;
      end else begin
        state_d = IDLE;
        len_d   = '0;
        dcnt_d  = '0;
      end
      done_d = state_q == MATCH && !is_digit;
      last_d = done_d ? len_q : last_q;
      cnt_d  = done_d && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      dcnt_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dcnt_q  <= dcnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  assign tok.match       = state_q == MATCH;
  assign tok.cur_len     = len_q;
  assign tok.token_done  = done_q;
  assign tok.last_len    = last_q;
  assign tok.token_count = cnt_q;
endmodule

// File: tb/tb_id_token_scanner.sv
// tb_id_token_scanner: directed checks of three scanner configurations fed from one character stream.
module tb_id_token_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ch = 8'd0;
  logic       vld = 1'b0, ue = 1'b0, clr = 1'b0;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  id_token_if #(.LEN_W(8), .CNT_W(16)) ia ();
  id_token_if #(.LEN_W(8), .CNT_W(16)) ib ();
  id_token_if #(.LEN_W(4), .CNT_W(2))  ic ();
  assign ia.char = ch; assign ia.char_valid = vld; assign ia.underscore_en = ue; assign ia.clear = clr;
  assign ib.char = ch; assign ib.char_valid = vld; assign ib.underscore_en = ue; assign ib.clear = clr;
  assign ic.char = ch; assign ic.char_valid = vld; assign ic.underscore_en = ue; assign ic.clear = clr;
  id_token_scanner #(.MIN_DIGITS(1), .LEN_W(8), .CNT_W(16)) da (.clk(clk), .rst_n(rst_n), .tok(ia));
  id_token_scanner #(.MIN_DIGITS(3), .LEN_W(8), .CNT_W(16)) db (.clk(clk), .rst_n(rst_n), .tok(ib));
  id_token_scanner #(.MIN_DIGITS(1), .LEN_W(4), .CNT_W(2))  dc (.clk(clk), .rst_n(rst_n), .tok(ic));

  task automatic send(input logic [7:0] c);
    ch = c; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (ia.match !== 1'b0) begin bad++; $display("FAIL reset_match got=%0d exp=0", ia.match); end
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL reset_cur_len got=%0d exp=0", ia.cur_len); end
    total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d exp=0", ia.token_done); end
    total++; if (ia.last_len !== 8'd0) begin bad++; $display("FAIL reset_last_len got=%0d exp=0", ia.last_len); end
    total++; if (ia.token_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ia.token_count); end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send("a");
    total++; if (ia.cur_len !== 8'd1) begin bad++; $display("FAIL basic_len_a got=%0d exp=1", ia.cur_len); end
    total++; if (ia.match !== 1'b0) begin bad++; $display("FAIL basic_match_a got=%0d exp=0", ia.match); end
    send("b");
    send("1");
    total++; if (ia.match !== 1'b1) begin bad++; $display("FAIL basic_match_1 got=%0d exp=1", ia.match); end
    total++; if (ia.cur_len !== 8'd3) begin bad++; $display("FAIL basic_len_1 got=%0d exp=3", ia.cur_len); end
    send("2");
    total++; if (ia.match !== 1'b1) begin bad++; $display("FAIL basic_match_2 got=%0d exp=1", ia.match); end
    total++; if (ia.cur_len !== 8'd4) begin bad++; $display("FAIL basic_len_2 got=%0d exp=4", ia.cur_len); end
    send(";");
    total++; if (ia.match !== 1'b0) begin bad++; $display("FAIL basic_match_end got=%0d exp=0", ia.match); end
    total++; if (ia.token_done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0d exp=1", ia.token_done); end
    total++; if (ia.last_len !== 8'd4) begin bad++; $display("FAIL basic_last_len got=%0d exp=4", ia.last_len); end
    total++; if (ia.token_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", ia.token_count); end
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL basic_len_end got=%0d exp=0", ia.cur_len); end
    idle(1);
    total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL basic_done_idle got=%0d exp=0", ia.token_done); end
  endtask

  task automatic test_min_digits();
    string s = "x12y";
    do_clear();
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      total++; if (ib.match !== 1'b0) begin bad++; $display("FAIL min3_nomatch_%0d got=%0d exp=0", i, ib.match); end
      total++; if (ib.token_done !== 1'b0) begin bad++; $display("FAIL min3_nodone_%0d got=%0d exp=0", i, ib.token_done); end
    end
    send(";");
    total++; if (ib.token_count !== 16'd0) begin bad++; $display("FAIL min3_count0 got=%0d exp=0", ib.token_count); end
    send("x"); send("1"); send("2");
    total++; if (ib.match !== 1'b0) begin bad++; $display("FAIL min3_match_2 got=%0d exp=0", ib.match); end
    send("3");
    total++; if (ib.match !== 1'b1) begin bad++; $display("FAIL min3_match_3 got=%0d exp=1", ib.match); end
    total++; if (ib.cur_len !== 8'd4) begin bad++; $display("FAIL min3_len got=%0d exp=4", ib.cur_len); end
    send(" ");
    total++; if (ib.token_done !== 1'b1) begin bad++; $display("FAIL min3_done got=%0d exp=1", ib.token_done); end
    total++; if (ib.last_len !== 8'd4) begin bad++; $display("FAIL min3_last_len got=%0d exp=4", ib.last_len); end
    total++; if (ib.token_count !== 16'd1) begin bad++; $display("FAIL min3_count got=%0d exp=1", ib.token_count); end
  endtask

  task automatic test_underscore();
    do_clear();
    ue = 1'b1;
    send("a"); send("_"); send("b"); send("9");
    total++; if (ia.match !== 1'b1) begin bad++; $display("FAIL us_on_match got=%0d exp=1", ia.match); end
    send("-");
    total++; if (ia.last_len !== 8'd4) begin bad++; $display("FAIL us_on_last_len got=%0d exp=4", ia.last_len); end
    total++; if (ia.token_count !== 16'd1) begin bad++; $display("FAIL us_on_count got=%0d exp=1", ia.token_count); end
    ue = 1'b0;
    send("a"); send("_");
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL us_off_len got=%0d exp=0", ia.cur_len); end
    send("b"); send("9");
    total++; if (ia.cur_len !== 8'd2) begin bad++; $display("FAIL us_off_len9 got=%0d exp=2", ia.cur_len); end
    send("-");
    total++; if (ia.token_done !== 1'b1) begin bad++; $display("FAIL us_off_done got=%0d exp=1", ia.token_done); end
    total++; if (ia.last_len !== 8'd2) begin bad++; $display("FAIL us_off_last_len got=%0d exp=2", ia.last_len); end
    total++; if (ia.token_count !== 16'd2) begin bad++; $display("FAIL us_off_count got=%0d exp=2", ia.token_count); end
  endtask

  task automatic test_back_to_back(input int gap);
    do_clear();
    send("a"); idle(gap); send("1"); idle(gap); send("b");
    total++; if (ia.token_done !== 1'b1) begin bad++; $display("FAIL b2b_done_b gap=%0d got=%0d exp=1", gap, ia.token_done); end
    total++; if (ia.last_len !== 8'd2) begin bad++; $display("FAIL b2b_last_b gap=%0d got=%0d exp=2", gap, ia.last_len); end
    idle(gap);
    if (gap > 0) begin
      total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL b2b_gap_done gap=%0d got=%0d exp=0", gap, ia.token_done); end
    end
    send("2");
    total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL b2b_done_2 gap=%0d got=%0d exp=0", gap, ia.token_done); end
    total++; if (ia.match !== 1'b1) begin bad++; $display("FAIL b2b_match_2 gap=%0d got=%0d exp=1", gap, ia.match); end
    idle(gap); send("c");
    total++; if (ia.token_done !== 1'b1) begin bad++; $display("FAIL b2b_done_c gap=%0d got=%0d exp=1", gap, ia.token_done); end
    total++; if (ia.last_len !== 8'd2) begin bad++; $display("FAIL b2b_last_c gap=%0d got=%0d exp=2", gap, ia.last_len); end
    total++; if (ia.token_count !== 16'd2) begin bad++; $display("FAIL b2b_count gap=%0d got=%0d exp=2", gap, ia.token_count); end
  endtask

  task automatic test_saturation();
    do_clear();
    send("a");
    repeat (20) send("7");
    total++; if (ic.cur_len !== 4'd15) begin bad++; $display("FAIL sat_len got=%0d exp=15", ic.cur_len); end
    total++; if (ic.match !== 1'b1) begin bad++; $display("FAIL sat_match got=%0d exp=1", ic.match); end
    total++; if (ia.cur_len !== 8'd21) begin bad++; $display("FAIL sat_wide_len got=%0d exp=21", ia.cur_len); end
    send(".");
    total++; if (ic.token_done !== 1'b1) begin bad++; $display("FAIL sat_done got=%0d exp=1", ic.token_done); end
    total++; if (ic.last_len !== 4'd15) begin bad++; $display("FAIL sat_last_len got=%0d exp=15", ic.last_len); end
    total++; if (ia.last_len !== 8'd21) begin bad++; $display("FAIL sat_wide_last got=%0d exp=21", ia.last_len); end
    repeat (4) begin send("a"); send("1"); send(";"); end
    total++; if (ic.token_count !== 2'd3) begin bad++; $display("FAIL sat_count got=%0d exp=3", ic.token_count); end
    total++; if (ia.token_count !== 16'd5) begin bad++; $display("FAIL sat_wide_count got=%0d exp=5", ia.token_count); end
  endtask

  task automatic test_async_reset();
    send("a"); send("b");
    ch = "1"; vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL arst_len got=%0d exp=0", ia.cur_len); end
    total++; if (ia.last_len !== 8'd0) begin bad++; $display("FAIL arst_last got=%0d exp=0", ia.last_len); end
    total++; if (ia.token_count !== 16'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", ia.token_count); end
    total++; if (ia.match !== 1'b0) begin bad++; $display("FAIL arst_match got=%0d exp=0", ia.match); end
    total++; if (ic.token_count !== 2'd0) begin bad++; $display("FAIL arst_count_c got=%0d exp=0", ic.token_count); end
    @(posedge clk); #1;
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL arst_hold_len got=%0d exp=0", ia.cur_len); end
    vld = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear();
    send("a"); send("1"); send(";"); send("a"); send("1");
    total++; if (ia.match !== 1'b1) begin bad++; $display("FAIL clr_pre_match got=%0d exp=1", ia.match); end
    total++; if (ia.token_count !== 16'd1) begin bad++; $display("FAIL clr_pre_count got=%0d exp=1", ia.token_count); end
    ch = "5"; vld = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0; clr = 1'b0;
    total++; if (ia.match !== 1'b0) begin bad++; $display("FAIL clr_match got=%0d exp=0", ia.match); end
    total++; if (ia.token_count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", ia.token_count); end
    total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL clr_done got=%0d exp=0", ia.token_done); end
    total++; if (ia.cur_len !== 8'd0) begin bad++; $display("FAIL clr_len got=%0d exp=0", ia.cur_len); end
    total++; if (ia.last_len !== 8'd0) begin bad++; $display("FAIL clr_last got=%0d exp=0", ia.last_len); end
    idle(1);
    total++; if (ia.token_done !== 1'b0) begin bad++; $display("FAIL clr_done_next got=%0d exp=0", ia.token_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_digits();
    test_underscore();
    test_back_to_back(0);
    test_back_to_back(2);
    test_saturation();
    test_async_reset();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
